// File: rtl/pipe_shifter_pkg.sv
// Shared constants and operation encodings for the two-stage barrel shifter.
package pipe_shifter_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRL = 2'b11
    } op_t;

endpackage

// File: rtl/pipe_shifter_shift_stage.sv
// One combinational barrel-shifter layer: moves data by a fixed distance D when enabled.
module shift_stage
    import pipe_shifter_pkg::*;
#(
    parameter int WIDTH = pipe_shifter_pkg::WIDTH,
    parameter int D     = 1
) (
    input  logic [WIDTH-1:0] data,
    input  op_t              op,
    input  logic             enable,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = data;
        if (enable) begin
            case (op)
                OP_ROL:  result = {data[WIDTH-1-D:0], data[WIDTH-1:WIDTH-D]};
                OP_SLL:  result = {data[WIDTH-1-D:0], {D{1'b0}}};
                OP_ROR:  result = {data[D-1:0], data[WIDTH-1:D]};
                OP_SRL:  result = {{D{1'b0}}, data[WIDTH-1:D]};
                default: result = data;
            endcase
        end
    end

endmodule

// File: rtl/pipe_shifter.sv
// Two-stage pipelined rotate/shift unit with valid/ready handshakes on both sides.
module pipe_shifter
    import pipe_shifter_pkg::*;
#(
    parameter int WIDTH = pipe_shifter_pkg::WIDTH,
    parameter int CNT_W = pipe_shifter_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_cnt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    op_t              in_op_t;
    logic [WIDTH-1:0] s1_mid;
    logic [WIDTH-1:0] s1_res;
    logic [WIDTH-1:0] s2_mid;
    logic [WIDTH-1:0] s2_res;

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_data_reg;
    op_t              s1_op_reg;
    logic [1:0]       s1_cnt_hi_reg;
    logic             s2_valid_reg;
    logic [WIDTH-1:0] s2_data_reg;

    logic             s2_adv;

    assign in_op_t = op_t'(in_op);

    // S2 can take new contents when empty or when its result is leaving now;
    // S1 follows the same rule, which chains the ready path back to out_ready only.
    assign s2_adv   = !s2_valid_reg || out_ready;
    assign in_ready = !s1_valid_reg || s2_adv;

    shift_stage #(.WIDTH(WIDTH), .D(1)) u_d1 (
        .data   (in_data),
        .op     (in_op_t),
        .enable (in_cnt[0]),
        .result (s1_mid)
    );

    shift_stage #(.WIDTH(WIDTH), .D(2)) u_d2 (
        .data   (s1_mid),
        .op     (in_op_t),
        .enable (in_cnt[1]),
        .result (s1_res)
    );

    shift_stage #(.WIDTH(WIDTH), .D(4)) u_d4 (
        .data   (s1_data_reg),
        .op     (s1_op_reg),
        .enable (s1_cnt_hi_reg[0]),
        .result (s2_mid)
    );

    shift_stage #(.WIDTH(WIDTH), .D(8)) u_d8 (
        .data   (s2_mid),
        .op     (s1_op_reg),
        .enable (s1_cnt_hi_reg[1]),
        .result (s2_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_reg <= in_valid;
            end
            if (s2_adv) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_data_reg <= s2_res;
                end
            end
        end
    end

    // Payload registers carry no reset; their validity is tracked by s1_valid_reg.
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            s1_data_reg   <= s1_res;
            s1_op_reg     <= in_op_t;
            s1_cnt_hi_reg <= in_cnt[CNT_W-1:2];
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_data  = s2_data_reg;

endmodule
